// File: rtl/demo_dual_sequencer.sv
// demo_dual_sequencer
// Scripted start/mode driver for two bus-bridge demo instances. It pulses start
// for the selected side(s) and then follows each side's ready handshake. Each
// wait has a timeout. The LED result is captured as each side completes.
module demo_dual_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int START_CYCLES = 4,
    parameter int TIMEOUT_W    = 24,
    parameter int BUSY_TIMEOUT = 1000,
    parameter int DONE_TIMEOUT = 2000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [1:0]            seq_sel,
    input  logic                  mode_a_in,
    input  logic                  mode_b_in,
    input  logic                  ready_a,
    input  logic                  ready_b,
    input  logic [DATA_WIDTH-1:0] led_a,
    input  logic [DATA_WIDTH-1:0] led_b,
    output logic                  start_a,
    output logic                  start_b,
    output logic                  mode_a,
    output logic                  mode_b,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err,
    output logic [DATA_WIDTH-1:0] led_a_cap,
    output logic [DATA_WIDTH-1:0] led_b_cap,
    output logic [7:0]            run_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_FINISH
    } state_t;

    localparam logic [TIMEOUT_W-1:0] PULSE_LAST = TIMEOUT_W'(START_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] BUSY_LIM   = TIMEOUT_W'(BUSY_TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] DONE_LIM   = TIMEOUT_W'(DONE_TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX    = '1;

    state_t                  state_reg, state_next;
    logic [1:0]              seq_reg;
    logic                    mode_a_reg, mode_b_reg;
    logic [1:0]              active_reg;   // bit 0 = side A, bit 1 = side B
    logic [1:0]              seen_reg;     // ready seen low since this set's pulse ended
    logic [1:0]              fin_reg;      // ready returned high, LED captured
    logic [1:0]              err_reg;
    logic [TIMEOUT_W-1:0]    cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0]   cap_reg  [2];
    logic [DATA_WIDTH-1:0]   cap_next [2];
    logic [7:0]              run_count_reg;

    logic [1:0]              ready_vec;
    logic [DATA_WIDTH-1:0]   led_vec [2];
    logic [1:0]              low_hit, fin_hit;
    logic [1:0]              seen_upd, fin_upd;
    logic                    sample_en, go_accept, enter_pulse;
    logic                    all_seen, all_fin, busy_tmo, done_tmo, more_sets;
    logic [1:0]              active_dec;

    assign ready_vec  = {ready_b, ready_a};
    assign led_vec[0] = led_a;
    assign led_vec[1] = led_b;

    // Ready is only tracked after the pulse ends, so a glitch inside PULSE is invisible.
    assign sample_en = (state_reg == ST_WAIT_BUSY) || (state_reg == ST_WAIT_DONE);
    assign go_accept = (state_reg == ST_IDLE) && go;

    // Per-side handshake tracking: low is sticky; completion needs an earlier low.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            assign low_hit[gi]  = sample_en && active_reg[gi] && !ready_vec[gi];
            assign fin_hit[gi]  = sample_en && active_reg[gi] && seen_reg[gi] &&
                                  !fin_reg[gi] && ready_vec[gi];
            assign seen_upd[gi] = seen_reg[gi] | low_hit[gi];
            assign fin_upd[gi]  = fin_reg[gi] | fin_hit[gi];
            assign cap_next[gi] = fin_hit[gi] ? led_vec[gi] : cap_reg[gi];
        end
    endgenerate

    assign all_seen  = ((seen_upd & active_reg) == active_reg);
    assign all_fin   = ((fin_upd & active_reg) == active_reg);
    assign busy_tmo  = (cnt_reg > BUSY_LIM);
    assign done_tmo  = (cnt_reg > DONE_LIM);
    // A-then-B runs still have side B to go after side A's set.
    assign more_sets = (seq_reg == 2'b10) && (active_reg == 2'b01);

    // Map the selection code to the set of sides that runs first.
    always_comb begin
        active_dec = 2'b01;
        case (seq_sel)
            2'b00:   active_dec = 2'b01;
            2'b01:   active_dec = 2'b10;
            2'b10:   active_dec = 2'b01;
            default: active_dec = 2'b11;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A completion takes priority over a timeout in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (go) state_next = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_reg >= PULSE_LAST) state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (all_seen)      state_next = ST_WAIT_DONE;
                else if (busy_tmo) state_next = ST_FINISH;
            end
            ST_WAIT_DONE: begin
                if (all_fin)       state_next = more_sets ? ST_PULSE : ST_FINISH;
                else if (done_tmo) state_next = ST_FINISH;
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The counter measures time spent in the current state. It restarts on every entry and saturates.
    assign enter_pulse = (state_next == ST_PULSE) && (state_reg != ST_PULSE);

    always_comb begin
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            cnt_next = cnt_reg;
        end else begin
            cnt_next = cnt_reg + TIMEOUT_W'(1);
        end
    end

    // Run context, error capture, handshake tracking and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_reg       <= 2'b00;
            mode_a_reg    <= 1'b0;
            mode_b_reg    <= 1'b0;
            active_reg    <= 2'b00;
            err_reg       <= 2'b00;
            seen_reg      <= 2'b00;
            fin_reg       <= 2'b00;
            cnt_reg       <= '0;
            cap_reg[0]    <= '0;
            cap_reg[1]    <= '0;
            run_count_reg <= 8'd0;
        end else begin
            cnt_reg    <= cnt_next;
            cap_reg[0] <= cap_next[0];
            cap_reg[1] <= cap_next[1];

            if (enter_pulse) begin
                seen_reg <= 2'b00;
                fin_reg  <= 2'b00;
            end else begin
                seen_reg <= seen_upd;
                fin_reg  <= fin_upd;
            end

            if (go_accept) begin
                seq_reg    <= seq_sel;
                mode_a_reg <= mode_a_in;
                mode_b_reg <= mode_b_in;
                active_reg <= active_dec;
                err_reg    <= 2'b00;
            end

            if (state_reg == ST_WAIT_BUSY && !all_seen && busy_tmo) begin
                err_reg <= active_reg & ~seen_upd;
            end

            if (state_reg == ST_WAIT_DONE) begin
                if (all_fin) begin
                    if (more_sets) active_reg <= 2'b10;
                end else if (done_tmo) begin
                    err_reg <= active_reg & ~fin_upd;
                end
            end

            if (state_reg == ST_FINISH && err_reg == 2'b00) begin
                run_count_reg <= run_count_reg + 8'd1;
            end
        end
    end

    // Output decode from the current state and the registered run context.
    always_comb begin
        start_a   = (state_reg == ST_PULSE) && active_reg[0];
        start_b   = (state_reg == ST_PULSE) && active_reg[1];
        busy      = (state_reg != ST_IDLE);
        done      = (state_reg == ST_FINISH);
        mode_a    = mode_a_reg;
        mode_b    = mode_b_reg;
        err       = err_reg;
        led_a_cap = cap_reg[0];
        led_b_cap = cap_reg[1];
        run_count = run_count_reg;
    end

endmodule

// File: tb/tb_demo_dual_sequencer.sv
// Directed bench for demo_dual_sequencer. Two small ready models play the demo
// instances. A run task drives go and observes each run.
module tb_demo_dual_sequencer;

    localparam int DW = 8;
    localparam int SC = 4;
    localparam int BT = 20;
    localparam int DT = 60;

    logic          clk = 1'b0;
    logic          rst, go;
    logic [1:0]    seq_sel;
    logic          mode_a_in, mode_b_in;
    logic          ready_a, ready_b;
    logic [DW-1:0] led_a, led_b;
    logic          start_a, start_b, mode_a, mode_b, busy, done;
    logic [1:0]    err;
    logic [DW-1:0] led_a_cap, led_b_cap;
    logic [7:0]    run_count;

    demo_dual_sequencer #(
        .DATA_WIDTH(DW), .START_CYCLES(SC), .TIMEOUT_W(24),
        .BUSY_TIMEOUT(BT), .DONE_TIMEOUT(DT)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .seq_sel(seq_sel),
        .mode_a_in(mode_a_in), .mode_b_in(mode_b_in),
        .ready_a(ready_a), .ready_b(ready_b), .led_a(led_a), .led_b(led_b),
        .start_a(start_a), .start_b(start_b), .mode_a(mode_a), .mode_b(mode_b),
        .busy(busy), .done(done), .err(err),
        .led_a_cap(led_a_cap), .led_b_cap(led_b_cap), .run_count(run_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Ready model configuration (cycles measured from the first idle cycle after start).
    int lo_a = 1, hi_a = 1, lo_b = 1, hi_b = 1;
    bit nolow_a = 0, nolow_b = 0, stuck_a = 0, rel_a = 0;

    task automatic model_a();
        while (!start_a) @(negedge clk);
        while (start_a) @(negedge clk);
        if (nolow_a) return;
        repeat (lo_a - 1) @(negedge clk);
        ready_a = 1'b0;
        if (stuck_a) begin
            while (!rel_a) @(negedge clk);
        end else begin
            repeat (hi_a) @(negedge clk);
        end
        ready_a = 1'b1;
    endtask

    task automatic model_b();
        while (!start_b) @(negedge clk);
        while (start_b) @(negedge clk);
        if (nolow_b) return;
        repeat (lo_b - 1) @(negedge clk);
        ready_b = 1'b0;
        repeat (hi_b) @(negedge clk);
        ready_b = 1'b1;
    endtask

    initial begin ready_a = 1'b1; forever model_a(); end
    initial begin ready_b = 1'b1; forever model_b(); end

    // Observations from the latest run.
    int         r_a_hi, r_b_hi, r_coin, r_lat, r_done;
    bit         r_b_early;
    logic [1:0] r_err;

    task automatic ideal();
        lo_a = 1; hi_a = 1; lo_b = 1; hi_b = 1;
        nolow_a = 0; nolow_b = 0; stuck_a = 0;
    endtask

    task automatic do_run(input logic [1:0] sel, input logic ma, input logic mb,
                          input bit go_busy, input bit go_fin, input string name);
        int cyc;
        bit got, a_low, a_rose;
        @(negedge clk);
        seq_sel = sel; mode_a_in = ma; mode_b_in = mb; go = 1'b1;
        cyc = 0; got = 0; a_low = 0; a_rose = 0;
        r_a_hi = 0; r_b_hi = 0; r_coin = 0; r_lat = 0; r_done = 0; r_b_early = 0; r_err = 2'b00;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            go = go_busy && (cyc == 2 || cyc == 6);
            if (start_a) r_a_hi++;
            if (start_b) r_b_hi++;
            if (start_a && start_b) r_coin++;
            if (!ready_a) a_low = 1;
            else if (a_low) a_rose = 1;
            if (start_b && !a_rose) r_b_early = 1;
            if (done) begin
                got = 1; r_done++; r_lat = cyc + 1; r_err = err;
                if (go_fin) go = 1'b1;
            end
        end
        if (!got) check_eq({name, " done seen"}, 32'd0, 32'd1);
        repeat (3) begin
            @(negedge clk);
            go = 1'b0;
            if (done) r_done++;
        end
        $display("run %s: sel=%b err=%b lat=%0d a_hi=%0d b_hi=%0d cap_a=%h cap_b=%h runs=%0d",
                 name, sel, r_err, r_lat, r_a_hi, r_b_hi, led_a_cap, led_b_cap, run_count);
    endtask

    initial begin
        int k;
        int dn;
        rst = 1'b1; go = 1'b0; seq_sel = 2'b00; mode_a_in = 1'b0; mode_b_in = 1'b0;
        led_a = 8'h00; led_b = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("reset ctl", {24'd0, start_a, start_b, mode_a, mode_b, busy, done, err}, 32'd0);
        check_eq("reset caps", {16'd0, led_a_cap, led_b_cap}, 32'd0);
        check_eq("reset run_count", {24'd0, run_count}, 32'd0);
        rst = 1'b0;

        // 1: A only, late response
        ideal(); lo_a = 3; hi_a = 50; led_a = 8'hA5;
        do_run(2'b00, 1'b1, 1'b0, 0, 0, "t1");
        check_eq("t1 start_a cycles", r_a_hi, SC);
        check_eq("t1 start_b cycles", r_b_hi, 0);
        check_eq("t1 mode_a", {31'd0, mode_a}, 32'd1);
        check_eq("t1 done pulses", r_done, 1);
        check_eq("t1 err", {30'd0, r_err}, 32'd0);
        check_eq("t1 led_a_cap", {24'd0, led_a_cap}, 32'hA5);
        check_eq("t1 run_count", {24'd0, run_count}, 32'd1);

        // Mode is held across idle input changes
        @(negedge clk); mode_a_in = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mode hold", {31'd0, mode_a}, 32'd1);

        // Minimum latency with an ideal responder: 1 + SC + 2 + 1
        ideal();
        do_run(2'b00, 1'b0, 1'b1, 0, 0, "lat");
        check_eq("lat cycles", r_lat, 1 + SC + 2 + 1);
        check_eq("lat mode_b", {30'd0, mode_a, mode_b}, 32'd1);

        // 2: A then B, both respond
        ideal(); lo_a = 2; hi_a = 5; lo_b = 2; hi_b = 3; led_a = 8'h3C; led_b = 8'hC3;
        do_run(2'b10, 1'b0, 1'b0, 0, 0, "t2");
        check_eq("t2 b before a done", {31'd0, r_b_early}, 32'd0);
        check_eq("t2 start_b cycles", r_b_hi, SC);
        check_eq("t2 caps", {16'd0, led_a_cap, led_b_cap}, 32'h3CC3);
        check_eq("t2 done pulses", r_done, 1);
        check_eq("t2 err", {30'd0, r_err}, 32'd0);
        check_eq("t2 run_count", {24'd0, run_count}, 32'd3);

        // 3: A and B together, B never drops ready
        ideal(); lo_a = 2; hi_a = 4; nolow_b = 1; led_a = 8'h5A; led_b = 8'h77;
        do_run(2'b11, 1'b0, 1'b0, 0, 0, "t3");
        check_eq("t3 coincident start", r_coin, SC);
        check_eq("t3 err", {30'd0, r_err}, 32'd2);
        check_eq("t3 caps", {16'd0, led_a_cap, led_b_cap}, 32'h5AC3);
        check_eq("t3 run_count", {24'd0, run_count}, 32'd3);

        // 4: A then B, A stuck low past the done timeout
        ideal(); stuck_a = 1; rel_a = 0; led_a = 8'h11;
        do_run(2'b10, 1'b0, 1'b0, 0, 0, "t4");
        check_eq("t4 err", {30'd0, r_err}, 32'd1);
        check_eq("t4 start_b cycles", r_b_hi, 0);
        check_eq("t4 run_count", {24'd0, run_count}, 32'd3);
        check_eq("t4 led_a_cap", {24'd0, led_a_cap}, 32'h5A);
        rel_a = 1;
        k = 0;
        while (!ready_a && k < 50) begin @(negedge clk); k++; end
        check_eq("t4 ready_a released", {31'd0, ready_a}, 32'd1);
        stuck_a = 0; rel_a = 0;

        // 6a: go pulses during the run and in FINISH are ignored
        ideal();
        do_run(2'b00, 1'b0, 1'b0, 1, 1, "t6");
        check_eq("t6 start_a cycles", r_a_hi, SC);
        check_eq("t6 done pulses", r_done, 1);
        check_eq("t6 idle after finish", {31'd0, busy}, 32'd0);
        check_eq("t6 run_count", {24'd0, run_count}, 32'd4);

        // 5: reset while waiting for ready to return
        ideal(); hi_a = 30; led_a = 8'h99;
        @(negedge clk); seq_sel = 2'b00; go = 1'b1;
        @(negedge clk); go = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("t5 busy before reset", {30'd0, busy, ready_a}, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5 ctl after reset", {24'd0, start_a, start_b, mode_a, mode_b, busy, done, err}, 32'd0);
        check_eq("t5 caps after reset", {16'd0, led_a_cap, led_b_cap}, 32'd0);
        check_eq("t5 run_count after reset", {24'd0, run_count}, 32'd0);
        dn = 0;
        repeat (2) begin @(negedge clk); if (done) dn++; end
        rst = 1'b0;
        k = 0;
        while (!ready_a && k < 100) begin @(negedge clk); if (done) dn++; k++; end
        check_eq("t5 no done during abort", dn, 0);
        ideal();
        do_run(2'b00, 1'b0, 1'b0, 0, 0, "t5");
        check_eq("t5 clean err", {30'd0, r_err}, 32'd0);
        check_eq("t5 clean led_a_cap", {24'd0, led_a_cap}, 32'h99);
        check_eq("t5 clean run_count", {24'd0, run_count}, 32'd1);

        // 6b: 255 more clean runs wrap the counter to 0
        for (int i = 0; i < 255; i++) begin
            do_run(2'b01, 1'b0, 1'b0, 0, 0, "wrap");
        end
        check_eq("t6 run_count wrap", {24'd0, run_count}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
